// File: rtl/sp_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_pkg
// Description : Shared encodings for the byte-enable single-port RAM:
//               read-during-write modes, controller states and a helper
//               that sizes the internal word index.
// Revision    : 1.0 - initial release
// ============================================================================
package sp_ram_pkg;

    // Read-during-write behaviour selectors
    localparam int RD_READ_FIRST  = 0;
    localparam int RD_WRITE_FIRST = 1;
    localparam int RD_NO_CHANGE   = 2;

    // Controller states
    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Width of an index that spans exactly DEPTH words (at least one bit)
    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : sp_ram_pkg
`default_nettype wire

// File: rtl/sp_ram_array.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_array
// Description : Storage array with per-byte write enables and a single
//               registered read port. The read-during-write flavour is
//               chosen at elaboration so that each variant maps onto the
//               matching block-RAM primitive mode.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_array
    import sp_ram_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int IDX_W   = 5,
    parameter int DEPTH   = 32,
    parameter int RD_MODE = RD_READ_FIRST
) (
    input  logic                clk,
    input  logic                en,
    input  logic                we,
    input  logic [IDX_W-1:0]    addr,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   rdata
);

    localparam int c_NB = DATA_W / 8;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // Byte-lane write: only enabled lanes of the addressed word change
    always_ff @(posedge clk) begin
        if (en && we) begin
            for (int i = 0; i < c_NB; i++) begin
                if (be[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    if (RD_MODE == RD_WRITE_FIRST) begin : g_write_first
        logic [DATA_W-1:0] w_merged;

        // Word as it will look once the enabled lanes are written
        always_comb begin
            w_merged = r_mem[addr];
            for (int i = 0; i < c_NB; i++) begin
                if (be[i]) begin
                    w_merged[8*i +: 8] = wdata[8*i +: 8];
                end
            end
        end

        // Read register returns the post-merge word on writes
        always_ff @(posedge clk) begin
            if (en) begin
                r_rdata <= we ? w_merged : r_mem[addr];
            end
        end
    end else if (RD_MODE == RD_NO_CHANGE) begin : g_no_change
        // Read register is left untouched by writes
        always_ff @(posedge clk) begin
            if (en && !we) begin
                r_rdata <= r_mem[addr];
            end
        end
    end else begin : g_read_first
        // Read register returns the pre-write word on writes
        always_ff @(posedge clk) begin
            if (en) begin
                r_rdata <= r_mem[addr];
            end
        end
    end

    assign rdata = r_rdata;

endmodule : sp_ram_array
`default_nettype wire

// File: rtl/sp_ram_be.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram_be
// Description : Single-port synchronous RAM with byte enables, selectable
//               read-during-write mode, optional output register and a
//               post-reset clear sweep. Holds the controller FSM, clear
//               counter, clear/user request mux, range check and the
//               response pipeline around sp_ram_array.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram_be
    import sp_ram_pkg::*;
#(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 6,
    parameter int DEPTH          = 32,
    parameter int RD_MODE        = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_be,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_busy
);

    localparam int                c_IDX_W     = idx_width(DEPTH);
    localparam int                c_NB        = DATA_W / 8;
    localparam logic [c_IDX_W-1:0] c_LAST     = c_IDX_W'(DEPTH - 1);
    // One extra bit so DEPTH == 2**ADDR_W does not wrap to zero
    localparam logic [ADDR_W:0]   c_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic              c_WR_RSP    = (RD_MODE != RD_NO_CHANGE);
    localparam logic [0:0]        c_RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;

    logic [0:0]         r_state;
    logic [c_IDX_W-1:0] r_cnt;

    logic               w_run;
    logic               w_accept;
    logic               w_in_range;
    logic               w_rsp_req;

    logic               w_arr_en;
    logic               w_arr_we;
    logic [c_IDX_W-1:0] w_arr_addr;
    logic [c_NB-1:0]    w_arr_be;
    logic [DATA_W-1:0]  w_arr_wdata;
    logic [DATA_W-1:0]  w_arr_rdata;

    logic               r_s1_valid;
    logic               r_s1_err;
    logic [DATA_W-1:0]  w_s1_data;

    logic               w_fin_valid;
    logic               w_fin_err;
    logic [DATA_W-1:0]  w_fin_data;

    logic               r_rsp_valid;
    logic               r_rsp_err;
    logic [DATA_W-1:0]  r_rsp_rdata;

    assign w_run      = (r_state == ST_RUN);
    assign w_accept   = req_valid && w_run;
    assign w_in_range = ({1'b0, req_addr} < c_DEPTH);
    // Reads always answer; writes answer unless the mode suppresses them
    assign w_rsp_req  = !req_we || c_WR_RSP;

    // Clear sweep: one word per cycle, then hand over to normal service
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_RST_STATE;
            r_cnt   <= '0;
        end else if (r_state == ST_INIT) begin
            r_cnt <= r_cnt + c_IDX_W'(1);
            if (r_cnt == c_LAST) begin
                r_state <= ST_RUN;
            end
        end
    end

    // Array port is owned by the sweep in INIT and by the requester in RUN;
    // out-of-range requests never touch the array
    always_comb begin
        w_arr_en    = 1'b0;
        w_arr_we    = 1'b0;
        w_arr_addr  = '0;
        w_arr_be    = '0;
        w_arr_wdata = '0;
        if (r_state == ST_INIT) begin
            w_arr_en    = !rst;
            w_arr_we    = 1'b1;
            w_arr_addr  = r_cnt;
            w_arr_be    = '1;
            w_arr_wdata = '0;
        end else begin
            w_arr_en    = w_accept && w_in_range && !rst;
            w_arr_we    = req_we;
            w_arr_addr  = req_addr[c_IDX_W-1:0];
            w_arr_be    = req_be;
            w_arr_wdata = req_wdata;
        end
    end

    sp_ram_array #(
        .DATA_W  (DATA_W),
        .IDX_W   (c_IDX_W),
        .DEPTH   (DEPTH),
        .RD_MODE (RD_MODE)
    ) u_array (
        .clk   (clk),
        .en    (w_arr_en),
        .we    (w_arr_we),
        .addr  (w_arr_addr),
        .be    (w_arr_be),
        .wdata (w_arr_wdata),
        .rdata (w_arr_rdata)
    );

    // Tag the request alongside the array read so data and status line up
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_accept && w_rsp_req;
            r_s1_err   <= !w_in_range;
        end
    end

    assign w_s1_data = r_s1_err ? '0 : w_arr_rdata;

    if (OUT_REG != 0) begin : g_out_reg
        logic              r_s2_valid;
        logic              r_s2_err;
        logic [DATA_W-1:0] r_s2_data;

        // Extra retiming stage between array and response outputs
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s2_valid <= 1'b0;
                r_s2_err   <= 1'b0;
                r_s2_data  <= '0;
            end else begin
                r_s2_valid <= r_s1_valid;
                r_s2_err   <= r_s1_err;
                r_s2_data  <= w_s1_data;
            end
        end

        assign w_fin_valid = r_s2_valid;
        assign w_fin_err   = r_s2_err;
        assign w_fin_data  = r_s2_data;
    end else begin : g_no_out_reg
        assign w_fin_valid = r_s1_valid;
        assign w_fin_err   = r_s1_err;
        assign w_fin_data  = w_s1_data;
    end

    // Response register: pulses valid, holds data/status between pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_fin_valid;
            if (w_fin_valid) begin
                r_rsp_err   <= w_fin_err;
                r_rsp_rdata <= w_fin_data;
            end
        end
    end

    assign req_ready = w_run;
    assign init_busy = (r_state == ST_INIT);
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;

endmodule : sp_ram_be
`default_nettype wire

// File: doc/sp_ram_be.md
# sp_ram_be

Parametrised single-port synchronous RAM with per-byte write enables, selectable read-during-write behaviour, an optional output register stage and a hardware clear engine that zeroes the array after reset. It is the general-purpose on-chip buffer for our sequential blocks. It supersedes fixed 8-bit/32-entry RAM instances wherever width, depth, partial writes or a known initial state matter.

## Interface
Parameters:
- DATA_W, 8: word width; must be a multiple of 8.
- ADDR_W, 6: address width.
- DEPTH, 32: number of words; DEPTH ≤ 2**ADDR_W.
- RD_MODE, 0: read-during-write behaviour. 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
- OUT_REG, 0: 1 adds one output register stage.
- CLEAR_ON_RESET, 1: 1 enables the post-reset zeroing sweep.

Ports:
- clk, in, 1: sole clock; all logic acts on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: request can be accepted.
- req_we, in, 1: 1 = write, 0 = read.
- req_addr, in, ADDR_W: word address.
- req_be, in, DATA_W/8: byte enables for writes; ignored on reads.
- req_wdata, in, DATA_W: write data.
- rsp_valid, out, 1: one-cycle pulse marking valid rsp_rdata and rsp_err.
- rsp_rdata, out, DATA_W: response data.
- rsp_err, out, 1: the responded request addressed a location ≥ DEPTH.
- init_busy, out, 1: clear sweep in progress.

## Operation
- Clock and reset are fixed: single clock clk, synchronous active-high rst.
- Reset values:
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - Output pipeline flushed.
  - init_busy = CLEAR_ON_RESET.
  - req_ready = !CLEAR_ON_RESET.
  - Array contents are not reset directly.
- FSM states:
  - INIT: clear counter starts at 0. Each cycle with rst low writes mem[cnt] = 0 and increments cnt. When cnt == DEPTH-1 is written, go to RUN.
  - RUN: normal service. Only rst leaves RUN; rst returns to INIT when CLEAR_ON_RESET = 1, else stays in RUN.
- Acceptance: a request is accepted on a rising edge where req_valid && req_ready. req_ready = (state == RUN). There is no response backpressure.
- Write: for each byte i with req_be[i] = 1, mem[addr][8i+7:8i] takes req_wdata. Other bytes are unchanged. req_be = 0 is a legal no-op write.
- Read: exactly one response per accepted read, carrying mem[addr], rsp_err = 0.
- Write response by RD_MODE:
  - READ_FIRST: rsp_valid pulses with the pre-write word.
  - WRITE_FIRST: rsp_valid pulses with the post-merge word.
  - NO_CHANGE: no response; rsp_rdata holds its previous value.
- Out of range (addr ≥ DEPTH): writes are dropped with no array change. Reads, and writes that produce a response under the active RD_MODE, return rsp_rdata = 0 with rsp_err = 1.
- Between pulses, rsp_rdata holds the last response value.

## Timing
- Response latency: accepted at edge N gives rsp_valid high for the cycle after edge N+1+OUT_REG.
- Throughput: one request per cycle back to back. Responses return in request order.
- Consecutive same-address write then read: the read returns the just-written merged word.
- Init length:
  - The sweep occupies exactly DEPTH cycles, counted from the first edge with rst low.
  - init_busy falls and req_ready rises together after the edge that writes DEPTH-1.
- Reset mid-sweep: the counter restarts at 0 and the full sweep repeats.
- Reset with responses in flight: in-flight responses are discarded; no rsp_valid appears after the rst edge.
- Requests presented while req_ready = 0 are ignored. The requester must hold them.

## Structure
- Package sp_ram_pkg holds:
  - RD_MODE encodings: RD_READ_FIRST = 0, RD_WRITE_FIRST = 1, RD_NO_CHANGE = 2.
  - FSM state encoding: ST_INIT, ST_RUN.
- One sub-module, sp_ram_array:
  - Storage array with byte-enable write and 1-cycle registered read.
  - RD_MODE is a parameter of this sub-module.
  - Keeps the array inferable as block RAM.
- The top level holds the FSM, clear counter, request mux (clear versus user), range check and optional output stage.

## Test plan
- Init: DEPTH = 32, CLEAR_ON_RESET = 1, rst for 2 cycles → init_busy high for exactly 32 cycles. Then read address 31 → rsp_rdata = 0x00, rsp_err = 0.
- Byte enables: DATA_W = 32. Write 0xAABBCCDD with be = 4'hF to address 5, then write 0x11223344 with be = 4'b0101 → read address 5 gives 0xAA22CC44.
- Read-during-write: write 0x55 over 0x12 at address 3 → READ_FIRST responds 0x12; WRITE_FIRST responds 0x55; NO_CHANGE gives no rsp_valid.
- Latency and back-to-back: OUT_REG = 1, 8 consecutive reads of addresses 0..7 → 8 consecutive rsp_valid cycles starting 2 cycles after the first accept, data in order.
- Out of range: DEPTH = 24, ADDR_W = 5. Write to address 30, then read address 30 → rsp_err = 1, rsp_rdata = 0. Addresses 0..23 are unchanged.
- Reset mid-operation: assert rst at sweep count 10 → sweep restarts; init_busy stays high for 32 further cycles. Assert rst with 2 reads in flight → no rsp_valid after the reset edge.
